// File: rtl/ahb_bridge_arbiter_pkg.sv
// Shared types and helpers for the AHB bridge arbiter.
// ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package ahb_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_rr_picker.sv
// Combinational winner select over the request vector.
// ARB_FIXED_PRIO_EN: lowest index wins, last is ignored.
module rr_picker
  import ahb_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] winner
);

  int idx;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found  = 1'b1;
        idx    = i;
        winner = idx[W-1:0];
      end
    end
  end
`else
  // Scan downward so the nearest requester after last wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Shares one AHB slave port of the APB bridge among several masters.
// ARB_FIXED_PRIO_EN: fixed priority, no hold limit.
module ahb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 8
) (
  input  logic                              Hclk,
  input  logic                              Hresetn,
  input  logic [NUM_MASTERS-1:0]            Hbusreq,
  input  logic [2*NUM_MASTERS-1:0]          Htrans_m,
  input  logic [NUM_MASTERS-1:0]            Hwrite_m,
  input  logic [32*NUM_MASTERS-1:0]         Haddr_m,
  input  logic [32*NUM_MASTERS-1:0]         Hwdata_m,
  input  logic                              Hreadyout,
  output logic [NUM_MASTERS-1:0]            Hgrant,
  output logic [idx_w(NUM_MASTERS)-1:0]     Hmaster,
  output logic [idx_w(NUM_MASTERS)-1:0]     Hmaster_d,
  output logic [1:0]                        Htrans,
  output logic                              Hwrite,
  output logic [31:0]                       Haddr,
  output logic [31:0]                       Hwdata,
  output logic                              Hreadyin
);

  localparam int N  = NUM_MASTERS;
  localparam int W  = idx_w(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [N-1:0] ONE = N'(1);

  arb_state_t  state;
  logic [W-1:0]  last_owner;
  logic [HW-1:0] hold_cnt;

  logic [1:0]  trans_a [N];
  logic [31:0] addr_a  [N];
  logic [31:0] wdata_a [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign trans_a[i] = Htrans_m[2*i +: 2];
    assign addr_a[i]  = Haddr_m[32*i +: 32];
    assign wdata_a[i] = Hwdata_m[32*i +: 32];
  end

  logic          owned;
  logic [1:0]    own_trans;
  logic          accepted;
  logic [HW-1:0] cnt_inc;
  logic          own_req;
  logic          others;
  logic          limit;
  logic          rearb;
  logic [W-1:0]  pick_last;
  logic          found;
  logic [W-1:0]  winner;

  assign owned     = (state == ARB_OWN);
  assign own_trans = trans_a[Hmaster];
  assign accepted  = owned &&
                     (own_trans == HTRANS_NONSEQ ||
                      own_trans == HTRANS_SEQ);
  assign cnt_inc   = hold_cnt + {{(HW-1){1'b0}}, accepted};
  assign own_req   = Hbusreq[Hmaster];
  assign others    = |(Hbusreq & ~(ONE << Hmaster));

  // Limit counts the beat accepted this cycle, so at most MAX_HOLD per grant.
`ifdef ARB_FIXED_PRIO_EN
  assign limit = 1'b0;
`else
  assign limit = (cnt_inc >= HW'(MAX_HOLD));
`endif

  assign rearb     = !own_req || (limit && others);
  assign pick_last = owned ? Hmaster : last_owner;

  rr_picker #(
    .N(N),
    .W(W)
  ) u_picker (
    .req   (Hbusreq),
    .last  (pick_last),
    .found (found),
    .winner(winner)
  );

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state      <= ARB_IDLE;
      Hgrant     <= '0;
      Hmaster    <= '0;
      Hmaster_d  <= '0;
      hold_cnt   <= '0;
      last_owner <= W'(N - 1);
    end else begin
      if (Hreadyout) Hmaster_d <= Hmaster;
      case (state)
        ARB_IDLE: begin
          if (found) begin
            state    <= ARB_OWN;
            Hgrant   <= ONE << winner;
            Hmaster  <= winner;
            hold_cnt <= '0;
          end
        end
        ARB_OWN: begin
          if (Hreadyout) begin
            if (rearb) begin
              last_owner <= Hmaster;
              hold_cnt   <= '0;
              if (found) begin
                Hgrant  <= ONE << winner;
                Hmaster <= winner;
              end else begin
                Hgrant <= '0;
                state  <= ARB_IDLE;
              end
            end else if (limit) begin
              hold_cnt <= '0;
            end else begin
              hold_cnt <= cnt_inc;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign Htrans   = owned ? own_trans : HTRANS_IDLE;
  assign Hwrite   = owned ? Hwrite_m[Hmaster] : 1'b0;
  assign Haddr    = owned ? addr_a[Hmaster] : 32'h0;
  assign Hwdata   = wdata_a[Hmaster_d];
  assign Hreadyin = Hreadyout;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Bench for ahb_bridge_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level arbitration model.
module tb_ahb_bridge_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  busreq;
  logic [2*N-1:0]  trans_m;
  logic [N-1:0]  write_m;
  logic [32*N-1:0] addr_m;
  logic [32*N-1:0] wdata_m;
  logic          ready;
  logic [N-1:0]  hgrant;
  logic [1:0]    hmaster;
  logic [1:0]    hmaster_d;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [31:0]   haddr;
  logic [31:0]   hwdata;
  logic          hreadyin;

  int checks = 0;
  int fails  = 0;

  ahb_bridge_arbiter #(
    .NUM_MASTERS(N),
    .MAX_HOLD   (HOLD)
  ) dut (
    .Hclk     (clk),
    .Hresetn  (rstn),
    .Hbusreq  (busreq),
    .Htrans_m (trans_m),
    .Hwrite_m (write_m),
    .Haddr_m  (addr_m),
    .Hwdata_m (wdata_m),
    .Hreadyout(ready),
    .Hgrant   (hgrant),
    .Hmaster  (hmaster),
    .Hmaster_d(hmaster_d),
    .Htrans   (htrans),
    .Hwrite   (hwrite),
    .Haddr    (haddr),
    .Hwdata   (hwdata),
    .Hreadyin (hreadyin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input bit rq, input logic [1:0] t,
                       input bit w, input logic [31:0] a,
                       input logic [31:0] d);
    busreq[i]         = rq;
    trans_m[2*i +: 2] = t;
    write_m[i]        = w;
    addr_m[32*i +: 32]  = a;
    wdata_m[32*i +: 32] = d;
  endtask

  // Arbitration model: who owns the address phase, from the rules alone
  function automatic int pick(input logic [N-1:0] rq, input int last);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (rq[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (rq[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  int m_own = -1;
  int m_hm = 0;
  int m_md = 0;
  int m_hold = 0;
  int m_last = N - 1;
  bit started = 0;

  always @(negedge clk) begin
    int w, cnt, nmd;
    bit oth, lim;
    if (started) begin
      chk("grant", 32'(hgrant), (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
      chk("master", 32'(hmaster), m_hm);
      chk("master_d", 32'(hmaster_d), m_md);
      chk("trans", 32'(htrans),
          (m_own >= 0) ? 32'(trans_m[2*m_hm +: 2]) : 32'd0);
      chk("write", 32'(hwrite), (m_own >= 0) ? 32'(write_m[m_hm]) : 32'd0);
      chk("addr", haddr, (m_own >= 0) ? addr_m[32*m_hm +: 32] : 32'd0);
      chk("wdata", hwdata, wdata_m[32*m_md +: 32]);
      chk("readyin", 32'(hreadyin), 32'(ready));
    end
    if (!rstn) begin
      m_own = -1; m_hm = 0; m_md = 0; m_hold = 0; m_last = N - 1;
      started = 1;
    end else if (started) begin
      nmd = ready ? m_hm : m_md;
      if (m_own < 0) begin
        w = pick(busreq, m_last);
        if (w >= 0) begin m_own = w; m_hm = w; m_hold = 0; end
      end else if (ready) begin
        cnt = m_hold + ((trans_m[2*m_own +: 2] >= 2'd2) ? 1 : 0);
        oth = 0;
        for (int j = 0; j < N; j++) if (j != m_own && busreq[j]) oth = 1;
`ifdef ARB_FIXED_PRIO_EN
        lim = 0;
`else
        lim = (cnt >= HOLD);
`endif
        if (!busreq[m_own] || (lim && oth)) begin
          m_last = m_own;
          m_hold = 0;
          w = pick(busreq, m_own);
          m_own = w;
          if (w >= 0) m_hm = w;
        end else begin
          m_hold = lim ? 0 : cnt;
        end
      end
      m_md = nmd;
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  int seq[$];
  int cnt;
  bit hit;

  initial begin
    rstn = 1'b0;
    busreq = '0; trans_m = '0; write_m = '0;
    addr_m = '0; wdata_m = '0; ready = 1'b1;
    for (int i = 0; i < N; i++) set_m(i, 0, 2'b00, 0, 32'h100 * i, 32'hD0 + i);
    tick(); tick();
    rstn = 1'b1;

    // Single transfer from M1
    set_m(1, 1, 2'b10, 1, 32'h8000_0004, 32'hA3);
    @(negedge clk);
    chk("single_latency", 32'(hgrant), 32'h0);
    tick();
    @(negedge clk);
    chk("single_grant", 32'(hgrant), 32'b0010);
    chk("single_addr", haddr, 32'h8000_0004);
    chk("single_trans", 32'(htrans), 32'h2);
    tick();
    set_m(1, 0, 2'b00, 0, 32'h8000_0004, 32'hA3);
    @(negedge clk);
    chk("single_wdata", hwdata, 32'hA3);
    tick();
    @(negedge clk);
    chk("single_release", 32'(hgrant), 32'h0);

    // Stall during M0 -> M1 handover
    do_reset();
    set_m(0, 1, 2'b10, 1, 32'h100, 32'h1111_0000);
    tick(); tick();
    set_m(0, 0, 2'b00, 0, 32'h100, 32'h1111_0000);
    set_m(1, 1, 2'b10, 1, 32'h200, 32'h2222_0000);
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_grant", 32'(hgrant), 32'b0001);
      chk("stall_master", 32'(hmaster), 32'h0);
      chk("stall_master_d", 32'(hmaster_d), 32'h0);
      chk("stall_wdata", hwdata, 32'h1111_0000);
      tick();
    end
    ready = 1'b1;
    tick();
    @(negedge clk);
    chk("handover_grant", 32'(hgrant), 32'b0010);
    chk("handover_master_d", 32'(hmaster_d), 32'h0);
    chk("handover_wdata", hwdata, 32'h1111_0000);

    // Reset mid-burst, then M0 wins even though M1 owned
    set_m(0, 1, 2'b10, 0, 32'h100, 32'h1111_0000);
    rstn = 1'b0;
    tick();
    @(negedge clk);
    chk("reset_grant", 32'(hgrant), 32'h0);
    chk("reset_trans", 32'(htrans), 32'h0);
    chk("reset_master", 32'(hmaster), 32'h0);
    rstn = 1'b1;

    // Hold limit: M0 bursts, M2 waiting
    set_m(1, 0, 2'b00, 0, 32'h200, 32'h2222_0000);
    set_m(2, 1, 2'b10, 0, 32'h300, 32'h3333_0000);
    tick();
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (hgrant != 4'b0001) break;
      cnt++;
      tick();
    end
    chk("hold_beats", cnt, 32'd8);
    chk("hold_next", 32'(hgrant), 32'b0100);
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      @(negedge clk);
      if (hgrant == 4'b0001) hit = 1;
    end
    chk("hold_regain", 32'(hit), 32'h1);

    // Rotation with everyone requesting
    do_reset();
    for (int i = 0; i < N; i++) set_m(i, 1, 2'b10, 0, 32'h100 * i, 32'hD0 + i);
    seq.delete();
    for (int c = 0; c < 80 && seq.size() < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (hgrant[i] && (seq.size() == 0 || seq[$] != i)) seq.push_back(i);
      tick();
    end
    chk("rot_count", seq.size(), 32'd5);
    for (int i = 0; i < seq.size(); i++) chk("rot_order", seq[i], i % N);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rstn  = ($urandom_range(0, 249) != 0);
      ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) busreq[i] = ~busreq[i];
        trans_m[2*i +: 2]   = 2'($urandom_range(0, 3));
        write_m[i]          = 1'($urandom_range(0, 1));
        addr_m[32*i +: 32]  = $urandom;
        wdata_m[32*i +: 32] = $urandom;
      end
      tick();
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
